// File: rtl/seq_match_logger.sv
// Timestamped detection logger: free-running cycle counter, timestamp FIFO,
// saturating match counter and sticky overflow flag for a host-side reader.
module seq_match_logger #(
  parameter int unsigned TS_W  = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             detected,
  input  logic             clear,
  input  logic             rd_en,
  output logic [TS_W-1:0]  rd_data,
  output logic             rd_valid,
  output logic             fifo_empty,
  output logic             fifo_full,
  output logic             overflow,
  output logic [CNT_W-1:0] match_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [TS_W-1:0]  ts_q, ts_d;
  logic [TS_W-1:0]  mem_q [DEPTH];
  logic [TS_W-1:0]  mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [TS_W-1:0]  rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic push_req_c, push_c, pop_c;

  // Next-state: clear dominates; a pop from a full FIFO frees room for a same-edge push.
  always_comb begin
    ts_d       = ts_q + TS_W'(1);
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    overflow_d = overflow_q;
    cnt_d      = cnt_q;

    push_req_c = detected & ~clear;
    pop_c      = rd_en & ~clear & (occ_q != '0);
    push_c     = push_req_c & ((occ_q != OCC_FULL) | pop_c);

    if (clear) begin
      ts_d       = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      occ_d      = '0;
      overflow_d = 1'b0;
      cnt_d      = '0;
    end else begin
      if (pop_c) begin
        rd_data_d  = mem_q[rd_ptr_q];
        rd_valid_d = 1'b1;
        rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      end
      if (push_c) begin
        mem_d[wr_ptr_q] = ts_q;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (push_req_c && !push_c) begin
        overflow_d = 1'b1;
      end
      if (push_req_c && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (push_c && !pop_c) begin
        occ_d = occ_q + OCC_W'(1);
      end else if (pop_c && !push_c) begin
        occ_d = occ_q - OCC_W'(1);
      end
    end

    empty_d = (occ_d == '0);
    full_d  = (occ_d == OCC_FULL);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_q       <= '0;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      ts_q       <= ts_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      cnt_q      <= cnt_d;
    end
  end

  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign fifo_empty  = empty_q;
  assign fifo_full   = full_q;
  assign overflow    = overflow_q;
  assign match_count = cnt_q;

endmodule
